array_input_deserializer: RTL and testbench



---
 rtl/array_input_deserializer_pkg.sv | 29 ++
 rtl/array_input_deserializer_if.sv | 32 +++
 rtl/array_input_deserializer_lane_bank.sv | 43 ++++
 rtl/array_input_deserializer.sv | 163 ++++++++++++++++
 tb/tb_array_input_deserializer.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/array_input_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// array_deser_pkg
// Shared constants and the FSM state type for array_input_deserializer and its
// lane register bank.
//   LANE_W                 : width of one systolic-array lane value
//   NUM_LANES              : lanes per frame (even)
//   BEATS                  : packet beats per frame (two lanes per beat)
//   PACKET_W               : width of one upstream packet word
//   BEAT_CNT_W             : width of the beat counter output
//   FEED_W                 : width of the flattened feed bus
//   DEFAULT_TIMEOUT_CYCLES : mid-frame idle limit (ARRAY_DESER_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
package array_deser_pkg;

  localparam int LANE_W                 = 16;
  localparam int NUM_LANES              = 16;
  localparam int BEATS                  = NUM_LANES / 2;
  localparam int PACKET_W               = 2 * LANE_W;
  localparam int BEAT_CNT_W             = 3;
  localparam int FEED_W                 = NUM_LANES * LANE_W;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } deser_state_e;

endpackage

// File: rtl/array_input_deserializer_if.sv
// -----------------------------------------------------------------------------
// array_deser_if
// Bundles the upstream packet handshake and the downstream feed handshake of
// array_input_deserializer.
//   in_data/in_valid/in_ready     : upstream packet stream (ready = back-pressure)
//   feed/feed_valid/feed_ack      : unpacked frame toward the systolic array
//   beat_cnt                      : beats accepted in the frame being collected
//   frame_err                     : sticky timeout-abort flag
// Modports: slave = deserializer side, master = producer/consumer side.
// -----------------------------------------------------------------------------
interface array_deser_if;
  import array_deser_pkg::*;

  logic [PACKET_W-1:0]   in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [FEED_W-1:0]     feed;
  logic                  feed_valid;
  logic                  feed_ack;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic                  frame_err;

  modport slave (
    input  in_data, in_valid, feed_ack,
    output in_ready, feed, feed_valid, beat_cnt, frame_err
  );

  modport master (
    output in_data, in_valid, feed_ack,
    input  in_ready, feed, feed_valid, beat_cnt, frame_err
  );
endinterface

// File: rtl/array_input_deserializer_lane_bank.sv
// -----------------------------------------------------------------------------
// deser_lane_bank
// NUM_LANES x LANE_W register file. One write per cycle loads the lane pair
// selected by the beat index: low packet half -> lane 2k, high half -> lane 2k+1.
// Lanes are cleared only by reset; otherwise they keep their last value.
//   clk, reset  : clock, asynchronous active-high reset
//   i_we        : write the selected lane pair this cycle
//   i_beat_idx  : beat index k selecting lanes 2k/2k+1
//   i_wdata     : packet word supplying both lanes
//   o_feed      : flattened lanes, lane i at [i*LANE_W +: LANE_W]
// -----------------------------------------------------------------------------
module deser_lane_bank
  import array_deser_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [BEAT_CNT_W-1:0] i_beat_idx,
  input  logic [PACKET_W-1:0]   i_wdata,
  output logic [FEED_W-1:0]     o_feed
);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] r_lane;
      logic              w_sel;

      assign w_sel = i_we && (i_beat_idx == BEAT_CNT_W'(gi / 2));

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_lane <= '0;
        end else if (w_sel) begin
          r_lane <= i_wdata[(gi % 2) * LANE_W +: LANE_W];
        end
      end

      assign o_feed[gi * LANE_W +: LANE_W] = r_lane;
    end
  endgenerate

endmodule

// File: rtl/array_input_deserializer.sv
// -----------------------------------------------------------------------------
// array_input_deserializer
// Unpacks an 8-beat, 32-bit packet stream into 16 lane feed words for the
// systolic array and holds the frame until the array acknowledges it.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : array_deser_if.slave (in_data/in_valid/in_ready upstream,
//                feed/feed_valid/feed_ack downstream, beat_cnt, frame_err)
// Optional feature (macro ARRAY_DESER_TIMEOUT_EN): a mid-frame idle counter
// aborts a stalled frame after TIMEOUT_CYCLES idle cycles and sets the sticky
// frame_err flag. Without the macro frame_err is tied 0 and COLLECT waits
// forever.
// -----------------------------------------------------------------------------
module array_input_deserializer
  import array_deser_pkg::*;
`ifdef ARRAY_DESER_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
)
`endif
(
  input  logic          clk,
  input  logic          reset,
  array_deser_if.slave  bus
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

  deser_state_e          r_state;
  logic                  r_in_ready;
  logic                  r_feed_valid;
  logic [BEAT_CNT_W-1:0] r_beat_cnt;
  logic                  w_accept;
  logic [FEED_W-1:0]     w_feed;

  assign w_accept = bus.in_valid && r_in_ready;

  // beat_cnt is 0 in IDLE, so it doubles as the lane-pair index for every beat.
  deser_lane_bank u_lane_bank (
    .clk        (clk),
    .reset      (reset),
    .i_we       (w_accept),
    .i_beat_idx (r_beat_cnt),
    .i_wdata    (bus.in_data),
    .o_feed     (w_feed)
  );

`ifdef ARRAY_DESER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_frame_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b1;
      r_feed_valid <= 1'b0;
      r_beat_cnt   <= '0;
      r_idle_cnt   <= '0;
      r_frame_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_beat_cnt <= BEAT_CNT_W'(1);
            r_idle_cnt <= '0;
            r_state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_accept) begin
            r_idle_cnt <= '0;
            if (r_beat_cnt == LAST_BEAT) begin
              r_beat_cnt   <= '0;
              r_in_ready   <= 1'b0;
              r_feed_valid <= 1'b1;
              r_state      <= HOLD;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end else if (r_idle_cnt == IDLE_LAST) begin
            // This is the TIMEOUT_CYCLES-th consecutive idle cycle: drop the frame.
            r_idle_cnt  <= '0;
            r_beat_cnt  <= '0;
            r_frame_err <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.feed_ack) begin
            r_feed_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_in_ready   <= 1'b1;
          r_feed_valid <= 1'b0;
          r_beat_cnt   <= '0;
          r_idle_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.frame_err = r_frame_err;
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_in_ready   <= 1'b1;
      r_feed_valid <= 1'b0;
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_beat_cnt <= BEAT_CNT_W'(1);
            r_state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_accept) begin
            if (r_beat_cnt == LAST_BEAT) begin
              r_beat_cnt   <= '0;
              r_in_ready   <= 1'b0;
              r_feed_valid <= 1'b1;
              r_state      <= HOLD;
            end else begin
              r_beat_cnt <= r_beat_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.feed_ack) begin
            r_feed_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_in_ready   <= 1'b1;
          r_feed_valid <= 1'b0;
          r_beat_cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.frame_err = 1'b0;
`endif

  assign bus.in_ready   = r_in_ready;
  assign bus.feed_valid = r_feed_valid;
  assign bus.beat_cnt   = r_beat_cnt;
  assign bus.feed       = w_feed;

endmodule

// File: tb/tb_array_input_deserializer.sv
// -----------------------------------------------------------------------------
// tb_array_input_deserializer
// Directed scenarios plus a randomized stream, each cycle compared against a
// frame-level reference model (queue of accepted beats, lane array, hold flag).
// With ARRAY_DESER_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=4
// and the timeout scenario is exercised as well.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_array_input_deserializer;
  import array_deser_pkg::*;

  localparam int TB_TIMEOUT = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  array_deser_if bus ();

`ifdef ARRAY_DESER_TIMEOUT_EN
  array_input_deserializer #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
`else
  array_input_deserializer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: frame-level view of the block.
  logic [LANE_W-1:0]   m_lanes [NUM_LANES];
  logic [PACKET_W-1:0] m_beats [$];
  bit                  m_holding;
  bit                  m_err;
  int                  m_idle;

  task automatic check_eq(input string tag, input logic [FEED_W-1:0] got,
                          input logic [FEED_W-1:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [FEED_W-1:0] model_feed();
    logic [FEED_W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_LANES; i++) f[i*LANE_W +: LANE_W] = m_lanes[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_LANES; i++) m_lanes[i] = '0;
    m_beats.delete();
    m_holding = 0;
    m_err     = 0;
    m_idle    = 0;
  endtask

  // Applies the frame rules for one rising edge with the given inputs.
  task automatic model_edge(input logic v, input logic [PACKET_W-1:0] d, input logic ack);
    int k;
    if (m_holding) begin
      if (ack) m_holding = 0;
    end else if (v) begin
      k = m_beats.size();
      m_lanes[2*k]   = d[LANE_W-1:0];
      m_lanes[2*k+1] = d[PACKET_W-1:LANE_W];
      m_beats.push_back(d);
      m_idle = 0;
      if (m_beats.size() == BEATS) begin
        m_beats.delete();
        m_holding = 1;
      end
    end else if (m_beats.size() > 0) begin
`ifdef ARRAY_DESER_TIMEOUT_EN
      m_idle++;
      if (m_idle == TB_TIMEOUT) begin
        m_beats.delete();
        m_idle = 0;
        m_err  = 1;
      end
`endif
    end
  endtask

  task automatic compare_all(input string ctx);
    check_eq({ctx, ".in_ready"},   FEED_W'(bus.in_ready),   FEED_W'(!m_holding));
    check_eq({ctx, ".feed_valid"}, FEED_W'(bus.feed_valid), FEED_W'(m_holding));
    check_eq({ctx, ".beat_cnt"},   FEED_W'(bus.beat_cnt),   FEED_W'(m_beats.size()));
    check_eq({ctx, ".frame_err"},  FEED_W'(bus.frame_err),  FEED_W'(m_err));
    check_eq({ctx, ".feed"},       bus.feed,                model_feed());
  endtask

  // One clock: drive inputs, let the edge happen, update the model, compare.
  task automatic cycle(input string ctx, input logic v, input logic [PACKET_W-1:0] d,
                       input logic ack);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.feed_ack = ack;
    @(posedge clk);
    model_edge(v, d, ack);
    #1;
    compare_all(ctx);
  endtask

  function automatic logic [PACKET_W-1:0] ramp_beat(input int k);
    return {LANE_W'(2*k+1), LANE_W'(2*k)};
  endfunction

  task automatic apply_reset(input string ctx);
    reset = 1'b1;
    #1;
    model_reset();
    compare_all({ctx, ".async"});
    @(posedge clk);
    #1;
    reset = 1'b0;
    compare_all({ctx, ".held"});
  endtask

  task automatic ramp_frame(input string ctx);
    for (int k = 0; k < BEATS; k++) cycle(ctx, 1'b1, ramp_beat(k), 1'b0);
  endtask

  initial begin
    logic [PACKET_W-1:0] rnd;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.feed_ack = 1'b0;
    model_reset();
    @(negedge clk);
    apply_reset("reset");

    // Single frame, lanes carry their own index.
    ramp_frame("single");
    for (int i = 0; i < NUM_LANES; i++)
      check_eq($sformatf("single.lane%0d", i), FEED_W'(bus.feed[i*LANE_W +: LANE_W]),
               FEED_W'(i));
    cycle("single.hold", 1'b0, '0, 1'b0);
    cycle("single.ack",  1'b0, '0, 1'b1);
    cycle("single.idle", 1'b0, '0, 1'b0);

    // Stalled stream: three idle cycles between beats 2 and 3.
    for (int k = 0; k < 3; k++) cycle("stall", 1'b1, ramp_beat(k), 1'b0);
    for (int s = 0; s < 3; s++) cycle("stall.gap", 1'b0, 32'hdead_beef, 1'b0);
    for (int k = 3; k < BEATS; k++) cycle("stall", 1'b1, ramp_beat(k), 1'b0);
    for (int i = 0; i < NUM_LANES; i++)
      check_eq($sformatf("stall.lane%0d", i), FEED_W'(bus.feed[i*LANE_W +: LANE_W]),
               FEED_W'(i));
    cycle("stall.ack", 1'b0, '0, 1'b1);

    // Back-pressure: valid held high, ack 5 cycles into HOLD.
    ramp_frame("bp");
    for (int s = 0; s < 5; s++) cycle("bp.hold", 1'b1, 32'h1111_2222 + s, 1'b0);
    cycle("bp.ack", 1'b1, 32'h3333_4444, 1'b1);
    cycle("bp.first", 1'b1, 32'haaaa_5555, 1'b0);
    check_eq("bp.lane0", FEED_W'(bus.feed[0 +: LANE_W]), FEED_W'(16'h5555));
    check_eq("bp.lane1", FEED_W'(bus.feed[LANE_W +: LANE_W]), FEED_W'(16'haaaa));
    for (int k = 1; k < BEATS; k++) cycle("bp.f2", 1'b1, $urandom, 1'b0);
    cycle("bp.ack2", 1'b0, '0, 1'b1);

    // Mid-frame reset after beat 4, then a fresh frame.
    for (int k = 0; k < 4; k++) cycle("midrst", 1'b1, $urandom, 1'b0);
    apply_reset("midrst.reset");
    ramp_frame("midrst.fresh");
    cycle("midrst.ack", 1'b0, '0, 1'b1);

    // Stray acks in IDLE and alongside beat 5.
    cycle("stray.idle", 1'b0, '0, 1'b1);
    for (int k = 0; k < BEATS; k++)
      cycle("stray", 1'b1, ramp_beat(k) ^ 32'h00ff_ff00, (k == 5) ? 1'b1 : 1'b0);
    cycle("stray.ack", 1'b0, '0, 1'b1);

`ifdef ARRAY_DESER_TIMEOUT_EN
    // Timeout: stop after beat 3 and let the idle limit expire.
    for (int k = 0; k < 3; k++) cycle("tmo", 1'b1, ramp_beat(k), 1'b0);
    for (int s = 0; s < TB_TIMEOUT + 2; s++) cycle("tmo.idle", 1'b0, '0, 1'b0);
    ramp_frame("tmo.next");
    cycle("tmo.ack", 1'b0, '0, 1'b1);
`endif

    // Randomized stream.
    for (int n = 0; n < 1500; n++) begin
      rnd = $urandom;
      cycle("rand", ($urandom_range(0, 3) != 0), rnd, ($urandom_range(0, 3) == 0));
      if (n % 17 == 0 && n > 0)
        for (int s = 0; s < int'($urandom_range(1, 6)); s++)
          cycle("rand.gap", 1'b0, $urandom, ($urandom_range(0, 1) == 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
